// File: rtl/dac0832_write_ctrl_pkg.sv
// Shared types and constants for the DAC0832 write controller.
// Contents: FSM state enum, mid-scale reset code, default timing constants and
// helpers that size the phase timer.
package dac0832_write_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStb1,
        StHold1,
        StStb2,
        StHold2
    } dac_state_e;

    localparam logic [7:0] DAC_MIDSCALE = 8'h80;

    // Default timings in sys_clk cycles (50 MHz: 100 ns / 500 ns / 100 ns).
    localparam int unsigned T_SU_DEFAULT = 5;
    localparam int unsigned T_WR_DEFAULT = 25;
    localparam int unsigned T_H_DEFAULT  = 5;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold a phase load value of (max_cycles - 1).
    function automatic int unsigned cnt_width(input int unsigned max_cycles);
        return (max_cycles <= 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/dac0832_write_ctrl_if.sv
// Bundle of the sample handshake and the DAC0832 pin group.
// slave  : view of the write controller (accepts samples, drives DAC pins).
// master : view of the upstream sample source / board-level observer.
interface dac0832_write_ctrl_if;

    logic [7:0] sample_in;     // offset-binary sample from the waveform mux
    logic       sample_valid;  // sample_in is valid
    logic       sample_ready;  // controller accepts the sample this cycle
    logic [7:0] data;          // DI7..DI0
    logic       ILE;           // input latch enable, active high
    logic       CS;            // chip select, active low
    logic       WR1;           // input-register strobe, active low
    logic       WR2;           // DAC-register strobe, active low
    logic       XFER;          // transfer control, active low
    logic       busy;          // write in progress
    logic       write_done;    // pulse in the last cycle of a write

    modport slave (
        input  sample_in, sample_valid,
        output sample_ready, data, ILE, CS, WR1, WR2, XFER, busy, write_done
    );

    modport master (
        output sample_in, sample_valid,
        input  sample_ready, data, ILE, CS, WR1, WR2, XFER, busy, write_done
    );

endinterface

// File: rtl/dac0832_write_ctrl_pulse_timer.sv
// Loadable down-counter used to time each write phase.
// Ports: clk_i/rst_ni (sync active-low), load_i/load_val_i load a new count,
// count_o is the current count, tc_o flags terminal count (zero).
// Without a load the counter decrements and then rests at zero.
module dac0832_write_ctrl_pulse_timer #(
    parameter int unsigned Width = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic [Width-1:0] count_o,
    output logic             tc_o
);

    localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - One;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == '0);

endmodule

// File: rtl/dac0832_write_ctrl.sv
// DAC0832 parallel write controller (double-buffered mode by default).
// Takes 8-bit samples over a valid/ready handshake with a 1-entry buffer and
// sequences CS/WR1/WR2/XFER with fixed setup, strobe and hold times. Every DAC
// pin comes straight from a register.
// Ports: sys_clk, reset_n (sync active-low); dac_bus.slave carries
// sample_in/sample_valid/sample_ready and data/ILE/CS/WR1/WR2/XFER/busy/
// write_done.
module dac0832_write_ctrl
    import dac0832_write_ctrl_pkg::*;
#(
    parameter int unsigned T_SU         = T_SU_DEFAULT,
    parameter int unsigned T_WR         = T_WR_DEFAULT,
    parameter int unsigned T_H          = T_H_DEFAULT,
    parameter bit          FLOW_THROUGH = 1'b0
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    dac0832_write_ctrl_if.slave   dac_bus
);

    localparam int unsigned CntW = cnt_width(max3(T_SU, T_WR, T_H));

    localparam logic [CntW-1:0] LoadSu = CntW'(T_SU - 1);
    localparam logic [CntW-1:0] LoadWr = CntW'(T_WR - 1);
    localparam logic [CntW-1:0] LoadH  = CntW'(T_H - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    // In single-buffer mode HOLD1 ends the write and WR2/XFER stay low.
    localparam dac_state_e FinalSt  = FLOW_THROUGH ? StHold1 : StHold2;
    localparam logic       Wr2Idle  = ~FLOW_THROUGH;
    localparam bit         HoldOne  = (T_H == 1);

    dac_state_e state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic       ile_q;
    logic       cs_q, cs_d;
    logic       wr1_q, wr1_d;
    logic       wr2_q, wr2_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic            sample_ready;
    logic            accept;
    logic            end_of_write;
    logic            tmr_load;
    logic [CntW-1:0] tmr_load_val;
    logic [CntW-1:0] tmr_count;
    logic            tmr_tc;

    assign sample_ready = !buf_full_q && reset_n;
    assign accept       = dac_bus.sample_valid && sample_ready;
    assign end_of_write = (state_q == FinalSt) && tmr_tc;

    dac0832_write_ctrl_pulse_timer #(
        .Width (CntW)
    ) u_timer (
        .clk_i      (sys_clk),
        .rst_ni     (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .count_o    (tmr_count),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;

        unique case (state_q)
            StIdle: begin
                if (buf_full_q) begin
                    state_d    = StSetup;
                    data_d     = buf_q;
                    buf_full_d = 1'b0;
                end else if (accept) begin
                    // Empty and idle: sample bypasses the buffer.
                    state_d = StSetup;
                    data_d  = dac_bus.sample_in;
                end
            end
            StSetup: if (tmr_tc) state_d = StStb1;
            StStb1:  if (tmr_tc) state_d = StHold1;
            StHold1: if (tmr_tc) state_d = FLOW_THROUGH ? StIdle : StStb2;
            StStb2:  if (tmr_tc) state_d = StHold2;
            StHold2: if (tmr_tc) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A pending sample chains straight into the next write, CS stays low.
        if (end_of_write && buf_full_q) begin
            state_d    = StSetup;
            data_d     = buf_q;
            buf_full_d = 1'b0;
        end

        // While a write is running (including its last cycle) samples are parked.
        if (accept && (state_q != StIdle)) begin
            buf_d      = dac_bus.sample_in;
            buf_full_d = 1'b1;
        end
    end

    always_comb begin
        tmr_load     = (state_d != state_q);
        tmr_load_val = '0;
        unique case (state_d)
            StSetup:         tmr_load_val = LoadSu;
            StStb1, StStb2:  tmr_load_val = LoadWr;
            StHold1, StHold2: tmr_load_val = LoadH;
            default:         tmr_load_val = '0;
        endcase
    end

    always_comb begin
        cs_d   = (state_d == StIdle);
        wr1_d  = (state_d != StStb1);
        wr2_d  = FLOW_THROUGH ? 1'b0 : (state_d != StStb2);
        busy_d = (state_d != StIdle);
        // Registered pulse must land on the final cycle of the final hold phase.
        done_d = (state_d == FinalSt) &&
                 (((state_q != FinalSt) && HoldOne) ||
                  ((state_q == FinalSt) && (tmr_count == CntOne)));
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            data_q     <= DAC_MIDSCALE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            ile_q      <= 1'b1;
            cs_q       <= 1'b1;
            wr1_q      <= 1'b1;
            wr2_q      <= Wr2Idle;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            ile_q      <= 1'b1;
            cs_q       <= cs_d;
            wr1_q      <= wr1_d;
            wr2_q      <= wr2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign dac_bus.sample_ready = sample_ready;
    assign dac_bus.data         = data_q;
    assign dac_bus.ILE          = ile_q;
    assign dac_bus.CS           = cs_q;
    assign dac_bus.WR1          = wr1_q;
    assign dac_bus.WR2          = wr2_q;
    assign dac_bus.XFER         = wr2_q;
    assign dac_bus.busy         = busy_q;
    assign dac_bus.write_done   = done_q;

endmodule

// File: tb/tb_dac0832_write_ctrl.sv
// Bench for dac0832_write_ctrl: scoreboard of samples checked at each WR1
// rising edge, plus directed timing checks (default and single-buffer modes).
module tb_dac0832_write_ctrl;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    dac0832_write_ctrl_if dif ();
    dac0832_write_ctrl_if fif ();

    dac0832_write_ctrl #(
        .T_SU (5), .T_WR (25), .T_H (5), .FLOW_THROUGH (1'b0)
    ) u_dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .dac_bus (dif)
    );

    dac0832_write_ctrl #(
        .T_SU (5), .T_WR (25), .T_H (5), .FLOW_THROUGH (1'b1)
    ) u_dut_ft (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .dac_bus (fif)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         done_cycs[$];

    // Monitor state for the default-mode instance.
    logic wr1_prev = 1'b1, wr2_prev = 1'b1, cs_prev = 1'b1;
    int wr1_low = 0, wr2_low = 0;
    int wr1_fall_cyc = -1, wr1_rise_cyc = -1, wr2_fall_cyc = -1, wr2_rise_cyc = -1;
    int cs_rise_cyc = -1;
    int wr1_falls = 0, wr2_falls = 0, cs_rises = 0, done_cnt = 0;

    always @(posedge sys_clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor: pops the expected sample whenever WR1 rises.
    always @(negedge sys_clk) begin
        if (!reset_n) begin
            wr1_prev = 1'b1; wr2_prev = 1'b1; cs_prev = 1'b1;
            wr1_low = 0; wr2_low = 0;
        end else begin
            if (!dif.WR1) wr1_low++;
            if (!dif.WR2) wr2_low++;
            if (wr1_prev && !dif.WR1) begin wr1_fall_cyc = cyc; wr1_falls++; end
            if (wr2_prev && !dif.WR2) begin wr2_fall_cyc = cyc; wr2_falls++; end
            if (!wr1_prev && dif.WR1) begin
                wr1_rise_cyc = cyc;
                if (exp_q.size() == 0) chk("wr1_unexpected_write", 1, 0);
                else chk("data_at_wr1_rise", dif.data, exp_q.pop_front());
                chk("wr1_low_width", wr1_low, 25);
                wr1_low = 0;
            end
            if (!wr2_prev && dif.WR2) begin
                wr2_rise_cyc = cyc;
                chk("wr2_low_width", wr2_low, 25);
                chk("xfer_follows_wr2", dif.XFER, 1);
                wr2_low = 0;
            end
            if (!cs_prev && dif.CS) begin cs_rise_cyc = cyc; cs_rises++; end
            if (dif.write_done) begin done_cnt++; done_cycs.push_back(cyc); end
            wr1_prev = dif.WR1; wr2_prev = dif.WR2; cs_prev = dif.CS;
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge E with e = E.
    task automatic send(input logic [7:0] d, output int e);
        int n;
        n = 0;
        dif.sample_in    = d;
        dif.sample_valid = 1'b1;
        while (!dif.sample_ready && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 300) chk("send_accept_timeout", 0, 1);
        else exp_q.push_back(d);
        @(negedge sys_clk);
        e = cyc;
        dif.sample_valid = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge sys_clk);
    endtask

    int e, e2, base_done, base_cs, base_w1, base_w2;
    int ft_bad, ft_wr1_low, ft_done_at, ft_cs_rise, ft_done_cnt;

    initial begin
        dif.sample_in = 8'h00; dif.sample_valid = 1'b0;
        fif.sample_in = 8'h00; fif.sample_valid = 1'b0;
        reset_n = 1'b0;

        // Reset and idle.
        repeat (3) @(negedge sys_clk);
        chk("ready_low_in_reset", dif.sample_ready, 0);
        reset_n = 1'b1;
        @(negedge sys_clk);
        chk("rst_data_midscale", dif.data, 8'h80);
        chk("rst_ctrl_pins", {dif.ILE, dif.CS, dif.WR1, dif.WR2, dif.XFER}, 5'b11111);
        chk("rst_busy_done", {dif.busy, dif.write_done}, 2'b00);
        chk("rst_ready_high", dif.sample_ready, 1);
        chk("ft_rst_wr2_xfer_low", {fif.WR2, fif.XFER}, 2'b00);

        // Single write.
        base_done = done_cnt;
        send(8'h3C, e);
        chk("single_cs_data_at_e", {dif.CS, dif.data, dif.busy}, {1'b0, 8'h3C, 1'b1});
        wait_until(e + 70);
        chk("single_wr1_fall", wr1_fall_cyc, e + 5);
        chk("single_wr1_rise", wr1_rise_cyc, e + 30);
        chk("single_wr2_fall", wr2_fall_cyc, e + 35);
        chk("single_wr2_rise", wr2_rise_cyc, e + 60);
        chk("single_done_count", done_cnt - base_done, 1);
        chk("single_done_cycle", done_cycs[$], e + 64);
        chk("single_cs_rise", cs_rise_cyc, e + 65);
        chk("single_data_held", dif.data, 8'h3C);

        // Back-to-back.
        base_cs = cs_rises;
        base_done = done_cnt;
        send(8'h11, e);
        send(8'hEE, e2);
        chk("b2b_ready_low_buffered", dif.sample_ready, 0);
        wait_until(e + 140);
        chk("b2b_done_count", done_cnt - base_done, 2);
        chk("b2b_period", done_cycs[$] - done_cycs[$-1], 65);
        chk("b2b_second_wr1_fall", wr1_fall_cyc, done_cycs[$-1] + 6);
        chk("b2b_single_cs_rise", cs_rises - base_cs, 1);
        chk("b2b_cs_rise_at_end", cs_rise_cyc, done_cycs[$] + 1);

        // Sample offered during the write_done cycle.
        send(8'h77, e);
        wait_until(e + 64);
        chk("same_cycle_done_high", dif.write_done, 1);
        chk("same_cycle_ready", dif.sample_ready, 1);
        dif.sample_in = 8'h55; dif.sample_valid = 1'b1;
        exp_q.push_back(8'h55);
        @(negedge sys_clk);
        dif.sample_valid = 1'b0;
        chk("same_cycle_idle_gap", {dif.busy, dif.CS}, 2'b01);
        @(negedge sys_clk);
        chk("same_cycle_restart", {dif.busy, dif.CS, dif.data}, {1'b1, 1'b0, 8'h55});
        wait_until(e + 140);
        chk("same_cycle_sb_empty", exp_q.size(), 0);

        // Reset during STB1 with a sample buffered.
        send(8'h9A, e);
        send(8'h5B, e2);
        wait_until(e + 10);
        chk("midrst_in_stb1", dif.WR1, 0);
        reset_n = 1'b0;
        @(negedge sys_clk);
        chk("midrst_pins", {dif.WR1, dif.CS, dif.busy}, 3'b110);
        chk("midrst_data", dif.data, 8'h80);
        reset_n = 1'b1;
        exp_q.delete();
        base_w1 = wr1_falls;
        base_w2 = wr2_falls;
        @(negedge sys_clk);
        chk("midrst_buffer_cleared", {dif.sample_ready, dif.busy}, 2'b10);
        repeat (100) @(negedge sys_clk);
        chk("midrst_no_wr2_pulse", wr2_falls - base_w2, 0);
        chk("midrst_no_new_write", wr1_falls - base_w1, 0);

        // Single-buffer instance.
        fif.sample_in = 8'hC3; fif.sample_valid = 1'b1;
        chk("ft_ready", fif.sample_ready, 1);
        @(negedge sys_clk);
        e = cyc;
        fif.sample_valid = 1'b0;
        ft_bad = 0; ft_wr1_low = 0; ft_done_at = -1; ft_cs_rise = -1; ft_done_cnt = 0;
        chk("ft_data_cs_at_e", {fif.CS, fif.data}, {1'b0, 8'hC3});
        for (int i = 0; i < 45; i++) begin
            if (fif.WR2 || fif.XFER) ft_bad++;
            if (!fif.WR1) ft_wr1_low++;
            if (fif.write_done) begin ft_done_at = cyc; ft_done_cnt++; end
            if (fif.CS && ft_cs_rise < 0) ft_cs_rise = cyc;
            @(negedge sys_clk);
        end
        chk("ft_wr2_xfer_always_low", ft_bad, 0);
        chk("ft_wr1_width", ft_wr1_low, 25);
        chk("ft_done_cycle", ft_done_at, e + 34);
        chk("ft_done_count", ft_done_cnt, 1);
        chk("ft_cs_rise", ft_cs_rise, e + 35);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
